wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Round-robin Wishbone arbiter that lets N bus masters share one Wishbone slave port, such as the configuration register slave at 0xB000_0000 that feeds the video pipeline. Any master holding CYC requests the bus. Exactly one master is granted at a time, and the granted master's signals are routed to the slave. A watchdog terminates transactions the slave never acknowledges, so a missing slave cannot hang the system.

## Interface
Parameters:
- N_MASTERS, 2, number of requesting masters (2..8)
- TIMEOUT, 255, cycles a strobe may wait for ACK/ERR/RTY before the arbiter forces ERR (1..65535)

Ports:
- p_clk  in  1  system clock, all state updates on rising edge
- p_resetn  in  1  reset; asynchronous, active-low
- m_cyc_i  in  N_MASTERS  per-master CYC
- m_stb_i  in  N_MASTERS  per-master STB
- m_we_i  in  N_MASTERS  per-master WE
- m_lock_i  in  N_MASTERS  per-master LOCK
- m_adr_i  in  N_MASTERS*32  packed addresses; master k at bits [32k+31:32k]
- m_dat_i  in  N_MASTERS*32  packed write data
- m_sel_i  in  N_MASTERS*4  packed byte selects
- m_dat_o  out  32  slave read data, broadcast to all masters
- m_ack_o / m_err_o / m_rty_o  out  N_MASTERS each  terminations, routed to the granted master only
- s_cyc_o, s_stb_o, s_we_o, s_lock_o  out  1 each  slave-side control
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_sel_o  out  4  slave byte selects
- s_dat_i  in  32  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations
- grant_o  out  N_MASTERS  one-hot current owner; all zero when idle
- busy_o  out  1  high while in OWNED

## Operation
- FSM has two states, IDLE and OWNED. Registers: state, grant (one-hot), rr_ptr (index of the highest-priority master), wd_cnt (16 bit).
- IDLE: if any m_cyc_i is high, pick the first requesting master scanning from rr_ptr upward, wrapping modulo N_MASTERS. Load grant, go to OWNED, and set rr_ptr to the winner+1 mod N_MASTERS.
- OWNED, slave side: s_* outputs carry the granted master's signals, a combinational mux on the grant register.
- OWNED, master side: terminations s_ack_i/s_err_i/s_rty_i are routed only to the granted master's bit of m_ack_o/m_err_o/m_rty_o.
- OWNED release: when the granted master has m_cyc_i=0 and m_lock_i=0, return to IDLE. LOCK high with CYC low keeps ownership (locked sequence).
- Outside OWNED: all s_* control outputs, all m_ack_o/m_err_o/m_rty_o, grant_o and busy_o are 0. s_adr_o, s_dat_o and s_sel_o are 0.
- Masters that are not granted never see ACK/ERR/RTY.
- Watchdog:
  - In OWNED with s_stb_o=1 and no slave termination, wd_cnt increments.
  - Any termination or s_stb_o=0 clears wd_cnt.
  - When wd_cnt reaches TIMEOUT-1 with the strobe still pending, in the next cycle m_err_o of the granted master is 1 for one cycle, s_stb_o is forced to 0, and wd_cnt clears.
  - A slave termination arriving in that same cycle is dropped; the forced ERR wins.
- Reset (async, any time, including mid-transfer): state=IDLE, grant=0, rr_ptr=0, wd_cnt=0. All outputs go 0 immediately.

## Timing
- Arbitration latency: a master raising CYC in IDLE at edge t is granted at edge t+1. Its signals appear on s_* in cycle t+1.
- Slave-to-master termination path is combinational, zero added latency. Single-cycle ACK slaves keep full throughput within an ownership.
- Master-to-slave path is combinational after the grant register. No data registers are inserted.
- Handover: the owner drops CYC at edge t and the FSM is IDLE at t+1. The next owner is granted at t+2, leaving one dead cycle between owners.
- Simultaneous requests: rr_ptr decides. After master k wins, master k+1 has top priority.
- A master dropping CYC before it is granted simply loses its request. There is no memory of past requests.

## Structure
- Package wb_arb_pkg holds the arb_state_t enum (IDLE, OWNED), the WB_ADR_W=32, WB_DAT_W=32 and WB_SEL_W=4 constants, and a function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module wb_arb_watchdog contains the counter, the compare against TIMEOUT and the force_err pulse. It is instantiated once.

## Test plan
- Reset: p_resetn low mid-transfer with grant=01. Required: all outputs 0 asynchronously, before the next edge. After release, master 1 requests alone and is granted at t+1.
- Single master: master 0 writes 0x0000_00AA to 0xB000_0004 and the slave ACKs in the same cycle. Required: s_adr_o=0xB000_0004 at t+1, m_ack_o=01, then grant_o=00 one cycle after CYC drops.
- Contention: masters 0 and 1 both hold CYC for 4 consecutive transfers each from reset. Required grant order 01, 10, 01, 10, with one idle cycle between owners.
- Lock: master 0 asserts LOCK, drops CYC for 3 cycles, then resumes while master 1 requests. Required: grant stays 01 throughout; master 1 is granted only after LOCK and CYC are both low.
- Watchdog: TIMEOUT=4 and the slave never answers. Required: m_err_o[0]=1 exactly 4 cycles after s_stb_o rises, s_stb_o=0 in that cycle, and wd_cnt restarts if the master re-strobes.
- Isolation: master 1 strobes without a grant while master 0 owns the bus and the slave ACKs. Required: m_ack_o[1] stays 0 every cycle.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types, bus widths and the round-robin pick helper for the Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int WB_ADR_W    = 32;
    localparam int WB_DAT_W    = 32;
    localparam int WB_SEL_W    = 4;
    localparam int MAX_MASTERS = 8;

    // Return a one-hot grant for the first requester found scanning upward
    // from ptr, wrapping modulo n. An empty request vector returns zero.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [2:0]             ptr,
        input int unsigned            n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic                   found;
        int unsigned            idx;
        logic [2:0]             idx3;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            idx  = ({29'd0, ptr} + i) % n;
            idx3 = idx[2:0];
            if (!found && (i < n) && req[idx3]) begin
                gnt[idx3] = 1'b1;
                found     = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Strobe watchdog: counts cycles a strobe waits without termination and
// raises a one-cycle force_err pulse once TIMEOUT cycles have elapsed.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    input  logic term_i,
    output logic force_err_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        force_q, force_d;

    // Count pending strobe cycles; on reaching the limit arm the forced error
    // for the next cycle. The forced cycle drops the strobe, which clears us.
    always_comb begin
        wd_cnt_d = '0;
        force_d  = 1'b0;
        if (stb_i && !term_i) begin
            if (wd_cnt_q == LIMIT) begin
                force_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
            force_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            force_q  <= force_d;
        end
    end

    assign force_err_o = force_q;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port. One owner at
// a time, combinational routing after the grant register, and a watchdog
// that forces ERR on strobes the slave never terminates.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                          p_clk,
    input  logic                          p_resetn,
    input  logic [N_MASTERS-1:0]          m_cyc_i,
    input  logic [N_MASTERS-1:0]          m_stb_i,
    input  logic [N_MASTERS-1:0]          m_we_i,
    input  logic [N_MASTERS-1:0]          m_lock_i,
    input  logic [N_MASTERS*WB_ADR_W-1:0] m_adr_i,
    input  logic [N_MASTERS*WB_DAT_W-1:0] m_dat_i,
    input  logic [N_MASTERS*WB_SEL_W-1:0] m_sel_i,
    output logic [WB_DAT_W-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]          m_ack_o,
    output logic [N_MASTERS-1:0]          m_err_o,
    output logic [N_MASTERS-1:0]          m_rty_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic                          s_lock_o,
    output logic [WB_ADR_W-1:0]           s_adr_o,
    output logic [WB_DAT_W-1:0]           s_dat_o,
    output logic [WB_SEL_W-1:0]           s_sel_o,
    input  logic [WB_DAT_W-1:0]           s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
    output logic [N_MASTERS-1:0]          grant_o,
    output logic                          busy_o
);

    // Handshake: a master requests by holding CYC; once granted, each cycle
    // with STB high is a transfer that completes in the cycle where ACK, ERR
    // or RTY is seen. LOCK keeps ownership across gaps in CYC.

    arb_state_t               state_q, state_d;
    logic [N_MASTERS-1:0]     grant_q, grant_d;
    logic [2:0]               rr_ptr_q, rr_ptr_d;

    logic [MAX_MASTERS-1:0]   req_pad;
    logic [MAX_MASTERS-1:0]   pick;
    logic [2:0]               win_idx;
    logic [2:0]               next_ptr;

    logic                     owned;
    logic                     own_cyc, own_stb, own_we, own_lock;
    logic [WB_ADR_W-1:0]      own_adr;
    logic [WB_DAT_W-1:0]      own_dat;
    logic [WB_SEL_W-1:0]      own_sel;
    logic [N_MASTERS-1:0]     gnt_mask;
    logic                     force_err;
    logic                     slv_term;

    assign owned = (state_q == OWNED);

    // Round-robin choice among current requesters and the pointer that follows it.
    always_comb begin
        req_pad = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req_pad[i] = m_cyc_i[i];
        end
        pick    = rr_pick(req_pad, rr_ptr_q, N_MASTERS);
        win_idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (pick[i]) begin
                win_idx = 3'(i);
            end
        end
        next_ptr = (win_idx == 3'(N_MASTERS - 1)) ? 3'd0 : win_idx + 3'd1;
    end

    // One-hot mux of the granted master's signals (all zero with no grant).
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        own_adr  = '0;
        own_dat  = '0;
        own_sel  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant_q[k]) begin
                own_cyc  = m_cyc_i[k];
                own_stb  = m_stb_i[k];
                own_we   = m_we_i[k];
                own_lock = m_lock_i[k];
                own_adr  = m_adr_i[WB_ADR_W*k +: WB_ADR_W];
                own_dat  = m_dat_i[WB_DAT_W*k +: WB_DAT_W];
                own_sel  = m_sel_i[WB_SEL_W*k +: WB_SEL_W];
            end
        end
    end

    // Next-state logic: claim the bus from IDLE, release when the owner
    // drops both CYC and LOCK.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d  = OWNED;
                    grant_d  = pick[N_MASTERS-1:0];
                    rr_ptr_d = next_ptr;
                end
            end
            OWNED: begin
                if (!own_cyc && !own_lock) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter FSM registers.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign slv_term = s_ack_i | s_err_i | s_rty_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i       (p_clk),
        .rst_ni      (p_resetn),
        .stb_i       (s_stb_o),
        .term_i      (slv_term),
        .force_err_o (force_err)
    );

    // Slave side: owner's signals, strobe withheld during a forced error.
    assign s_cyc_o  = owned & own_cyc;
    assign s_stb_o  = owned & own_stb & ~force_err;
    assign s_we_o   = owned & own_we;
    assign s_lock_o = owned & own_lock;
    assign s_adr_o  = owned ? own_adr : '0;
    assign s_dat_o  = owned ? own_dat : '0;
    assign s_sel_o  = owned ? own_sel : '0;

    // Master side: terminations reach only the owner; a forced error
    // overrides anything the slave returns in that cycle.
    assign gnt_mask = owned ? grant_q : '0;
    assign m_ack_o  = gnt_mask & {N_MASTERS{s_ack_i & ~force_err}};
    assign m_rty_o  = gnt_mask & {N_MASTERS{s_rty_i & ~force_err}};
    assign m_err_o  = gnt_mask & {N_MASTERS{s_err_i | force_err}};
    assign m_dat_o  = owned ? s_dat_i : '0;

    assign grant_o  = grant_q;
    assign busy_o   = owned;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a vector table for single-master and
// contention traffic, then hand-written reset, lock, watchdog and routing sequences.
module tb_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;
    localparam logic [31:0] ADR0 = 32'hB000_0004;
    localparam logic [31:0] ADR1 = 32'hB000_0010;
    localparam logic [31:0] DAT0 = 32'h0000_00AA;
    localparam logic [31:0] DAT1 = 32'h0000_0BB0;

    // ---------------- clock / reset ----------------
    logic p_clk    = 1'b0;
    logic p_resetn = 1'b0;
    always #5 p_clk = ~p_clk;

    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i, m_lock_i;
    logic [N*32-1:0] m_adr_i, m_dat_i;
    logic [N*4-1:0]  m_sel_i;
    logic [31:0]     m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic            s_cyc_o, s_stb_o, s_we_o, s_lock_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_dat_i;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
        .p_clk    (p_clk),
        .p_resetn (p_resetn),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_lock_i (m_lock_i),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_sel_i  (m_sel_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_rty_o  (m_rty_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_lock_o (s_lock_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .s_rty_i  (s_rty_i),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic step();
        @(posedge p_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc_i  = '0;
        m_stb_i  = '0;
        m_lock_i = '0;
        s_ack_i  = 1'b0;
        s_err_i  = 1'b0;
        s_rty_i  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        p_resetn = 1'b0;
        step();
        p_resetn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  cyc, stb, lock;
        logic        ack, err;
        logic [1:0]  e_gnt, e_ack, e_err;
        logic        e_sstb;
        logic [31:0] e_sadr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic rst, logic [1:0] cyc, logic [1:0] stb,
                                logic [1:0] lock, logic ack, logic err, logic [1:0] e_gnt,
                                logic [1:0] e_ack, logic [1:0] e_err, logic e_sstb,
                                logic [31:0] e_sadr);
        vec_t v;
        v.name = name; v.rst = rst; v.cyc = cyc; v.stb = stb; v.lock = lock;
        v.ack = ack; v.err = err; v.e_gnt = e_gnt; v.e_ack = e_ack; v.e_err = e_err;
        v.e_sstb = e_sstb; v.e_sadr = e_sadr;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic        m1_err;
        logic [31:0] e_sdat;
        clear_inputs();
        m_we_i  = 2'b01;
        m_adr_i = {ADR1, ADR0};
        m_dat_i = {DAT1, DAT0};
        m_sel_i = 8'hFF;
        s_dat_i = 32'h0000_5A5A;
        step();

        // Single master 0 write with same-cycle ACK, then release.
        add("single", 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
        add("single", 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
        add("single", 0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
        add("single", 0, 2'b01, 2'b01, 2'b00, 1, 0, 2'b01, 2'b01, 2'b00, 1, ADR0);
        add("single", 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0, ADR0);
        add("single", 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
        // Contention from reset: both request, alternate ownership four times each.
        add("contend", 1, 2'b11, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
        for (int r = 0; r < 4; r++) begin
            m1_err = (r == 3);
            add("contend", 0, 2'b11, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
            add("contend", 0, 2'b11, 2'b11, 2'b00, 1, 0, 2'b01, 2'b01, 2'b00, 1, ADR0);
            add("contend", 0, 2'b10, 2'b10, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0, ADR0);
            add("contend", 0, 2'b11, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
            add("contend", 0, 2'b11, 2'b11, 2'b00, !m1_err, m1_err, 2'b10,
                m1_err ? 2'b00 : 2'b10, m1_err ? 2'b10 : 2'b00, 1, ADR1);
            add("contend", 0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 0, ADR1);
        end
        add("contend", 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 32'h0);

        foreach (vecs[i]) begin
            p_resetn = ~vecs[i].rst;
            m_cyc_i  = vecs[i].cyc;
            m_stb_i  = vecs[i].stb;
            m_lock_i = vecs[i].lock;
            s_ack_i  = vecs[i].ack;
            s_err_i  = vecs[i].err;
            #4;
            e_sdat = vecs[i].e_gnt[0] ? DAT0 : (vecs[i].e_gnt[1] ? DAT1 : 32'h0);
            chk($sformatf("%s[%0d] grant_o", vecs[i].name, i), grant_o, vecs[i].e_gnt);
            chk($sformatf("%s[%0d] busy_o", vecs[i].name, i), busy_o, vecs[i].e_gnt != 2'b00);
            chk($sformatf("%s[%0d] m_ack_o", vecs[i].name, i), m_ack_o, vecs[i].e_ack);
            chk($sformatf("%s[%0d] m_err_o", vecs[i].name, i), m_err_o, vecs[i].e_err);
            chk($sformatf("%s[%0d] s_stb_o", vecs[i].name, i), s_stb_o, vecs[i].e_sstb);
            chk($sformatf("%s[%0d] s_cyc_o", vecs[i].name, i), s_cyc_o,
                |(vecs[i].e_gnt & vecs[i].cyc));
            chk($sformatf("%s[%0d] s_adr_o", vecs[i].name, i), s_adr_o, vecs[i].e_sadr);
            chk($sformatf("%s[%0d] s_dat_o", vecs[i].name, i), s_dat_o, e_sdat);
            step();
        end

        // Asynchronous reset in the middle of an acknowledged transfer.
        do_reset();
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        step();
        s_ack_i = 1'b1;
        s_dat_i = 32'h5555_AAAA;
        #1;
        chk("rst_pre grant_o", grant_o, 2'b01);
        chk("rst_pre m_ack_o", m_ack_o, 2'b01);
        #1;
        p_resetn = 1'b0;
        #1;
        chk("rst_async grant_o", grant_o, 2'b00);
        chk("rst_async busy_o", busy_o, 1'b0);
        chk("rst_async s_cyc_o", s_cyc_o, 1'b0);
        chk("rst_async s_stb_o", s_stb_o, 1'b0);
        chk("rst_async s_adr_o", s_adr_o, 32'h0);
        chk("rst_async s_dat_o", s_dat_o, 32'h0);
        chk("rst_async m_ack_o", m_ack_o, 2'b00);
        chk("rst_async m_dat_o", m_dat_o, 32'h0);
        step();
        clear_inputs();
        p_resetn = 1'b1;
        m_cyc_i  = 2'b10;
        m_stb_i  = 2'b10;
        #4;
        chk("rst_after idle grant_o", grant_o, 2'b00);
        step();
        #4;
        chk("rst_after m1 grant_o", grant_o, 2'b10);
        step();
        clear_inputs();
        step();
        step();

        // Locked sequence: master 0 keeps the bus across a 3-cycle CYC gap.
        do_reset();
        m_cyc_i  = 2'b01;
        m_stb_i  = 2'b01;
        m_lock_i = 2'b01;
        #4;
        chk("lock idle grant_o", grant_o, 2'b00);
        step();
        s_ack_i = 1'b1;
        #4;
        chk("lock own grant_o", grant_o, 2'b01);
        chk("lock own m_ack_o", m_ack_o, 2'b01);
        step();
        s_ack_i = 1'b0;
        m_cyc_i = 2'b10;
        m_stb_i = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("lock gap%0d grant_o", c), grant_o, 2'b01);
            chk($sformatf("lock gap%0d busy_o", c), busy_o, 1'b1);
            chk($sformatf("lock gap%0d s_cyc_o", c), s_cyc_o, 1'b0);
            chk($sformatf("lock gap%0d s_lock_o", c), s_lock_o, 1'b1);
            step();
        end
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        s_ack_i = 1'b1;
        #4;
        chk("lock resume grant_o", grant_o, 2'b01);
        chk("lock resume m_ack_o", m_ack_o, 2'b01);
        step();
        s_ack_i  = 1'b0;
        m_cyc_i  = 2'b10;
        m_stb_i  = 2'b10;
        m_lock_i = 2'b00;
        #4;
        chk("lock drop grant_o", grant_o, 2'b01);
        step();
        #4;
        chk("lock dead grant_o", grant_o, 2'b00);
        step();
        #4;
        chk("lock m1 grant_o", grant_o, 2'b10);
        chk("lock m1 s_adr_o", s_adr_o, ADR1);
        step();
        clear_inputs();
        step();
        step();

        // Watchdog with a silent slave; master 1 strobes without a grant throughout.
        do_reset();
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        #4;
        chk("wd idle grant_o", grant_o, 2'b00);
        step();
        for (int c = 1; c <= 12; c++) begin
            s_ack_i = (c == 5) || (c == 7);
            #4;
            chk($sformatf("wd c%0d grant_o", c), grant_o, 2'b01);
            chk($sformatf("wd c%0d m_err_o", c), m_err_o,
                ((c == 5) || (c == 12)) ? 2'b01 : 2'b00);
            chk($sformatf("wd c%0d s_stb_o", c), s_stb_o, !((c == 5) || (c == 12)));
            chk($sformatf("wd c%0d m_ack_o", c), m_ack_o, (c == 7) ? 2'b01 : 2'b00);
            step();
        end
        clear_inputs();
        step();
        step();

        // Routing of write data, byte selects, WE and read data for master 1.
        do_reset();
        m_adr_i = {32'hB000_0008, ADR0};
        m_dat_i = {32'h1234_5678, 32'h0};
        m_sel_i = {4'h3, 4'hF};
        m_we_i  = 2'b10;
        m_cyc_i = 2'b10;
        m_stb_i = 2'b10;
        s_dat_i = 32'hCAFE_F00D;
        #4;
        chk("route idle m_dat_o", m_dat_o, 32'h0);
        step();
        #4;
        chk("route s_adr_o", s_adr_o, 32'hB000_0008);
        chk("route s_dat_o", s_dat_o, 32'h1234_5678);
        chk("route s_sel_o", s_sel_o, 4'h3);
        chk("route s_we_o", s_we_o, 1'b1);
        chk("route s_cyc_o", s_cyc_o, 1'b1);
        chk("route m_dat_o", m_dat_o, 32'hCAFE_F00D);
        step();
        clear_inputs();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
